// File: rtl/vend_pkg.sv
// Shared types, coin values, event codes and price lookup for the vending controller.
package vend_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, HOLD, CHANGE} state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] code;
  } evt_t;

  localparam logic [6:0] COIN_NICKEL  = 7'd5;
  localparam logic [6:0] COIN_DIME    = 7'd10;
  localparam logic [6:0] COIN_QUARTER = 7'd25;
  localparam logic [6:0] COIN_DOLLAR  = 7'd100;

  localparam logic [7:0] EVT_COIN_OK    = 8'h01;
  localparam logic [7:0] EVT_COIN_REJ   = 8'h02;
  localparam logic [7:0] EVT_LOW_CREDIT = 8'h04;
  localparam logic [7:0] EVT_DONE       = 8'h05;
  localparam logic [7:0] EVT_CHANGE     = 8'h06;
  localparam logic [7:0] EVT_VEND       = 8'h10;

  function automatic logic [6:0] coin_value(input logic [1:0] sel);
    case (sel)
      2'b00:   coin_value = COIN_NICKEL;
      2'b01:   coin_value = COIN_DIME;
      2'b10:   coin_value = COIN_QUARTER;
      default: coin_value = COIN_DOLLAR;
    endcase
  endfunction

  function automatic int unsigned price_lookup(input logic [1:0] id, input int unsigned pa,
                                               input int unsigned pb, input int unsigned pc,
                                               input int unsigned pd);
    case (id)
      2'd0:    price_lookup = pa;
      2'd1:    price_lookup = pb;
      2'd2:    price_lookup = pc;
      default: price_lookup = pd;
    endcase
  endfunction
endpackage

// File: rtl/vend_evt_buf.sv
// Single-entry event holding register toward the UART formatter, with sticky drop flag.
module vend_evt_buf
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  evt_t       push,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_overflow
);
  logic load;

  // A pop and a push in the same cycle replace the entry without a bubble.
  assign load = push.vld && (!evt_valid || evt_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evt_valid    <= 1'b0;
      evt_code     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (load) begin
        evt_valid <= 1'b1;
        evt_code  <= push.code;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (push.vld && !load) evt_overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/vend_ctrl.sv
// Vending control FSM: credit tracking, vend/hold handshake with the delay timer, change payout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_A  = 75,
  parameter int unsigned PRICE_B  = 100,
  parameter int unsigned PRICE_C  = 125,
  parameter int unsigned PRICE_D  = 150,
  parameter int          CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  input  logic                delay_pulse,
  output logic                delay_enable,
  output logic                delay_clear,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [1:0]          dispense_id,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  input  logic                change_ack,
  output logic                evt_valid,
  output logic [7:0]          evt_code,
  input  logic                evt_ready,
  output logic                evt_overflow
);
  localparam int SW = CREDIT_W + 1;

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_n, price, chg_amt_n;
  logic [SW-1:0]       coin_sum;
  logic                coin_fits, disp_n, clr_n, rej_n, en_n, chg_v_n;
  logic [1:0]          disp_id_n;
  evt_t                push;

  // Carry out of the widened sum means the coin would overflow the credit register.
  assign coin_sum  = {1'b0, credit} + SW'(coin_value(coin_sel));
  assign coin_fits = !coin_sum[CREDIT_W];
  assign price     = CREDIT_W'(price_lookup(sel_id, PRICE_A, PRICE_B, PRICE_C, PRICE_D));

  always_comb begin
    state_n   = state;
    credit_n  = credit;
    disp_n    = 1'b0;
    disp_id_n = 2'd0;
    clr_n     = 1'b0;
    rej_n     = 1'b0;
    push      = '0;
    case (state)
      IDLE: if (coin_valid) begin
        if (coin_fits) begin
          credit_n = coin_sum[CREDIT_W-1:0];
          state_n  = CREDIT;
          push     = '{vld: 1'b1, code: EVT_COIN_OK};
        end else begin
          rej_n = 1'b1;
          push  = '{vld: 1'b1, code: EVT_COIN_REJ};
        end
      end
      CREDIT: begin
        if (cancel) begin
          state_n = CHANGE;
          rej_n   = coin_valid;
        end else if (sel_valid) begin
          rej_n = coin_valid;
          if (credit >= price) begin
            credit_n  = credit - price;
            disp_n    = 1'b1;
            disp_id_n = sel_id;
            clr_n     = 1'b1;
            state_n   = HOLD;
            push      = '{vld: 1'b1, code: EVT_VEND | {6'd0, sel_id}};
          end else begin
            push = '{vld: 1'b1, code: EVT_LOW_CREDIT};
          end
        end else if (coin_valid) begin
          if (coin_fits) begin
            credit_n = coin_sum[CREDIT_W-1:0];
            push     = '{vld: 1'b1, code: EVT_COIN_OK};
          end else begin
            rej_n = 1'b1;
            push  = '{vld: 1'b1, code: EVT_COIN_REJ};
          end
        end
      end
      HOLD: begin
        rej_n = coin_valid;
        if (delay_pulse) begin
          state_n = (credit != '0) ? CHANGE : IDLE;
          push    = '{vld: 1'b1, code: EVT_DONE};
        end else if (coin_valid) begin
          push = '{vld: 1'b1, code: EVT_COIN_REJ};
        end
      end
      CHANGE: begin
        rej_n = coin_valid;
        if (change_ack) begin
          credit_n = '0;
          state_n  = IDLE;
          push     = '{vld: 1'b1, code: EVT_CHANGE};
        end else if (coin_valid) begin
          push = '{vld: 1'b1, code: EVT_COIN_REJ};
        end
      end
      default: state_n = IDLE;
    endcase
    // Enable starts one cycle after the clear strobe and drops right after the timer pulse.
    en_n      = (state == HOLD) && (state_n == HOLD);
    chg_v_n   = (state_n == CHANGE);
    chg_amt_n = chg_v_n ? credit_n : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      credit        <= '0;
      dispense      <= 1'b0;
      dispense_id   <= 2'd0;
      delay_clear   <= 1'b0;
      delay_enable  <= 1'b0;
      coin_reject   <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= '0;
    end else begin
      state         <= state_n;
      credit        <= credit_n;
      dispense      <= disp_n;
      dispense_id   <= disp_id_n;
      delay_clear   <= clr_n;
      delay_enable  <= en_n;
      coin_reject   <= rej_n;
      change_valid  <= chg_v_n;
      change_amount <= chg_amt_n;
    end
  end

  vend_evt_buf u_evt (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .evt_ready    (evt_ready),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_overflow (evt_overflow)
  );
endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: directed strobes, queued expectations, negedge monitors.
module tb_vend_ctrl;
  logic       clk, reset;
  logic       coin_valid, sel_valid, cancel, delay_pulse, change_ack, evt_ready;
  logic [1:0] coin_sel, sel_id, dispense_id;
  logic       delay_enable, delay_clear, dispense, coin_reject, change_valid;
  logic       evt_valid, evt_overflow;
  logic [7:0] credit, change_amount, evt_code;

  vend_ctrl dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .delay_pulse(delay_pulse),
    .delay_enable(delay_enable), .delay_clear(delay_clear), .credit(credit),
    .dispense(dispense), .dispense_id(dispense_id), .coin_reject(coin_reject),
    .change_valid(change_valid), .change_amount(change_amount), .change_ack(change_ack),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_overflow(evt_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   nvec = 0, nerr = 0;
  int   evt_q[$], disp_q[$], chg_q[$];
  logic chg_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {delay_enable, delay_clear, credit, dispense, dispense_id, coin_reject,
               change_valid, change_amount, evt_valid, evt_code, evt_overflow}, 32'd0);
  endtask

  // Inputs change 2 ns after the active edge; monitors sample on the falling edge.
  task automatic step();
    @(posedge clk); #2;
  endtask
  task automatic coin(input logic [1:0] s);
    coin_valid = 1'b1; coin_sel = s; step(); coin_valid = 1'b0;
  endtask
  task automatic sel(input logic [1:0] id);
    sel_valid = 1'b1; sel_id = id; step(); sel_valid = 1'b0;
  endtask
  task automatic pulse();
    delay_pulse = 1'b1; step(); delay_pulse = 1'b0;
  endtask
  task automatic do_cancel();
    cancel = 1'b1; step(); cancel = 1'b0;
  endtask
  task automatic ack();
    change_ack = 1'b1; step(); change_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chg_prev = 1'b0;
    end else begin
      if (evt_valid && evt_ready) begin
        nvec++;
        if (evt_q.size() == 0) begin
          nerr++;
          $display("FAIL evt_unexpected: got %0h expected none", evt_code);
        end else begin
          int e;
          e = evt_q.pop_front();
          if (evt_code !== 8'(e)) begin
            nerr++;
            $display("FAIL evt_code: got %0h expected %0h", evt_code, e);
          end
        end
      end
      if (dispense) begin
        nvec++;
        if (disp_q.size() == 0) begin
          nerr++;
          $display("FAIL dispense_unexpected: got id %0d expected none", dispense_id);
        end else begin
          int d;
          d = disp_q.pop_front();
          if (dispense_id !== 2'(d)) begin
            nerr++;
            $display("FAIL dispense_id: got %0d expected %0d", dispense_id, d);
          end
        end
      end
      if (change_valid && !chg_prev) begin
        nvec++;
        if (chg_q.size() == 0) begin
          nerr++;
          $display("FAIL change_unexpected: got %0d expected none", change_amount);
        end else begin
          int c;
          c = chg_q.pop_front();
          if (change_amount !== 8'(c)) begin
            nerr++;
            $display("FAIL change_amount: got %0d expected %0d", change_amount, c);
          end
        end
      end
      chg_prev = change_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; coin_valid = 0; coin_sel = 0; sel_valid = 0; sel_id = 0; cancel = 0;
    delay_pulse = 0; change_ack = 0; evt_ready = 1'b1;
    #1 reset = 1'b1;
    #2 chk_all_zero("reset_outputs");
    step(); step(); reset = 1'b0; step();

    // 3 quarters, buy product 0 exactly, timer returns, no change.
    for (int i = 0; i < 3; i++) begin
      evt_q.push_back(8'h01); coin(2'b10);
      chk("t1_credit", credit, 25 * (i + 1));
    end
    evt_q.push_back(8'h10); disp_q.push_back(0); sel(2'd0);
    chk("t1_credit_after_vend", credit, 0);
    chk("t1_clear_en", {delay_clear, delay_enable}, 2'b10);
    step();
    chk("t1_enable", {delay_clear, delay_enable}, 2'b01);
    step(); step();
    evt_q.push_back(8'h05); pulse();
    chk("t1_after_pulse", {delay_enable, change_valid}, 2'b00);
    step();

    // Dollar, buy product 0, 25 change.
    evt_q.push_back(8'h01); coin(2'b11);
    evt_q.push_back(8'h10); disp_q.push_back(0); sel(2'd0);
    chk("t2_credit_hold", credit, 25);
    step();
    evt_q.push_back(8'h05); chg_q.push_back(25); pulse();
    chk("t2_change", {change_valid, change_amount}, {1'b1, 8'd25});
    step();
    evt_q.push_back(8'h06); ack();
    chk("t2_after_ack", {change_valid, credit}, 9'd0);
    step();

    // Credit 250 + dime rejected, nickel tops out at 255.
    evt_q.push_back(8'h01); coin(2'b11);
    evt_q.push_back(8'h01); coin(2'b11);
    evt_q.push_back(8'h01); coin(2'b10);
    evt_q.push_back(8'h01); coin(2'b10);
    chk("t3_credit_250", credit, 250);
    evt_q.push_back(8'h02); coin(2'b01);
    chk("t3_reject", {coin_reject, credit}, {1'b1, 8'd250});
    evt_q.push_back(8'h01); coin(2'b00);
    chk("t3_credit_255", {coin_reject, credit}, {1'b0, 8'd255});
    chg_q.push_back(255); do_cancel();
    chk("t3_cancel_change", change_valid, 1);
    evt_q.push_back(8'h06); ack();
    step();

    // Low credit, then cancel+select+coin in one cycle.
    evt_q.push_back(8'h01); coin(2'b10);
    evt_q.push_back(8'h01); coin(2'b10);
    evt_q.push_back(8'h04); sel(2'd1);
    chk("t4_low_credit", {dispense, credit}, {1'b0, 8'd50});
    chg_q.push_back(50);
    cancel = 1; sel_valid = 1; sel_id = 2'd1; coin_valid = 1; coin_sel = 2'b10;
    step();
    cancel = 0; sel_valid = 0; coin_valid = 0;
    chk("t4_priority", {coin_reject, dispense, change_valid, change_amount}, {3'b101, 8'd50});
    step();
    evt_q.push_back(8'h06); ack();
    step();

    // Stalled formatter: first event held, later two dropped.
    evt_ready = 1'b0;
    evt_q.push_back(8'h01); coin(2'b10);
    coin(2'b10);
    chk("t5_hold_code", {evt_valid, evt_code}, {1'b1, 8'h01});
    coin(2'b10);
    chk("t5_overflow", {evt_valid, evt_code, evt_overflow}, {1'b1, 8'h01, 1'b1});
    chk("t5_credit", credit, 75);
    evt_ready = 1'b1;
    step();
    chk("t5_drained", {evt_valid, evt_overflow}, 2'b01);
    chg_q.push_back(75); do_cancel();
    evt_q.push_back(8'h06); ack();
    step();

    // Reset while holding for the timer; stray pulse afterwards does nothing.
    evt_q.push_back(8'h01); coin(2'b11);
    evt_q.push_back(8'h10); disp_q.push_back(0); sel(2'd0);
    step();
    chk("t6_enable_before_reset", delay_enable, 1);
    reset = 1'b1;
    #1 chk_all_zero("t6_reset_in_hold");
    step(); reset = 1'b0; step();
    pulse();
    chk("t6_stray_pulse", {delay_enable, change_valid, evt_valid, credit}, 11'd0);
    step();
    evt_q.push_back(8'h01); coin(2'b10);
    chk("t6_idle_coin", credit, 25);
    chg_q.push_back(25); do_cancel();
    evt_q.push_back(8'h06); ack();
    step(); step();

    chk("evt_queue_empty", evt_q.size(), 0);
    chk("disp_queue_empty", disp_q.size(), 0);
    chk("chg_queue_empty", chg_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
